// File: rtl/bldc_pkg.sv
// Shared types and hall-sequence helpers for the BLDC velocity path.
//   hall_code_t : raw/filtered hall code {C,B,A}
//   velocity_t  : signed step count per sample window
//   HALL_SEQ    : forward commutation order, index 0..5
//   hall_index  : code -> sequence index, HALL_IDX_ILLEGAL for 000/111
package bldc_pkg;

    typedef logic [2:0]        hall_code_t;
    typedef logic signed [15:0] velocity_t;

    localparam hall_code_t HALL_SEQ [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    localparam logic [2:0] HALL_IDX_ILLEGAL = 3'd7;
    localparam int unsigned HALL_SEQ_LEN    = 6;

    // Symmetric saturation limit so that +/- ranges match.
    localparam int signed VEL_LIMIT = 32767;

    // Position of a code in the forward sequence, or HALL_IDX_ILLEGAL.
    function automatic logic [2:0] hall_index(input hall_code_t code);
        logic [2:0] idx;
        idx = HALL_IDX_ILLEGAL;
        for (int i = 0; i < 6; i++) begin
            if (HALL_SEQ[i] == code) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Hall input conditioning: multi-flop synchroniser followed by a glitch
// filter that accepts a code only after FILTER_CYCLES identical samples.
//   clk, reset    : clock, async active-high reset
//   hall          : raw asynchronous hall lines
//   code          : filtered hall code (000 after reset)
//   code_changed  : 1-cycle pulse when code takes a new value
module hall_input_filter
    import bldc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  hall_code_t hall,
    output hall_code_t code,
    output logic       code_changed
);

    localparam int unsigned CNT_W = ($clog2(FILTER_CYCLES + 1) < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    hall_code_t       sync_q [SYNC_STAGES];
    hall_code_t       synced;
    hall_code_t       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             accept_c;

    // Synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= hall;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Run length of the current synced sample, counting this cycle's sample,
    // so acceptance lands exactly FILTER_CYCLES samples after the change.
    always_comb begin
        cnt_next = CNT_W'(1);
        if (synced == cand_q) begin
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        accept_c = (cnt_next >= CNT_MAX) && (synced != code);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q       <= '0;
            cnt_q        <= '0;
            code         <= '0;
            code_changed <= 1'b0;
        end else begin
            cand_q       <= synced;
            cnt_q        <= cnt_next;
            code_changed <= accept_c;
            if (accept_c) begin
                code <= synced;
            end
        end
    end

endmodule

// File: rtl/bldc_hall_velocity_estimator.sv
// Hall-sensor velocity estimator: decodes filtered hall transitions into
// +/-1 steps, accumulates them over a fixed window and publishes a signed
// velocity with a 1-cycle strobe. Illegal codes and skipped steps raise
// hall_fault for the window in which they occur.
//   clk, reset      : clock, async active-high reset
//   hall            : raw hall lines {C,B,A}
//   velocity        : steps counted in the last completed window
//   velocity_valid  : 1-cycle pulse at each window end
//   direction       : sign of the most recent counted step (1 = reverse)
//   hall_fault      : last window saw an illegal code or skipped step
module bldc_hall_velocity_estimator
    import bldc_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 50000,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  hall_code_t hall,
    output velocity_t  velocity,
    output logic       velocity_valid,
    output logic       direction,
    output logic       hall_fault
);

    localparam int unsigned WIN_W = ($clog2(WINDOW_CYCLES) < 1) ? 1 : $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    hall_code_t        filt_code;
    logic              code_changed;

    logic [WIN_W-1:0]  win_cnt;
    velocity_t         acc;
    logic              fault_flag;
    logic [2:0]        ref_idx;
    logic              ref_valid;

    logic [2:0]        new_idx_c;
    logic              illegal_c;
    logic [3:0]        delta_c;
    logic signed [1:0] step_c;
    logic              fault_c;
    logic signed [16:0] sum_c;
    velocity_t         acc_next_c;
    logic              window_end_c;

    hall_input_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .hall         (hall),
        .code         (filt_code),
        .code_changed (code_changed)
    );

    // Transition decode: forward/reverse step, or fault on illegal/skipped code.
    always_comb begin
        new_idx_c = hall_index(filt_code);
        illegal_c = (new_idx_c == HALL_IDX_ILLEGAL);
        delta_c   = 4'(new_idx_c) + 4'(HALL_SEQ_LEN) - 4'(ref_idx);
        if (delta_c >= 4'(HALL_SEQ_LEN)) begin
            delta_c = delta_c - 4'(HALL_SEQ_LEN);
        end
        step_c  = 2'sd0;
        fault_c = 1'b0;
        if (code_changed) begin
            if (illegal_c) begin
                fault_c = 1'b1;
            end else if (ref_valid) begin
                if (delta_c == 4'd1) begin
                    step_c = 2'sd1;
                end else if (delta_c == 4'(HALL_SEQ_LEN - 1)) begin
                    step_c = -2'sd1;
                end else if (delta_c != 4'd0) begin
                    fault_c = 1'b1;
                end
            end
        end
    end

    // Saturating accumulate including this cycle's step.
    always_comb begin
        sum_c = 17'(acc) + 17'(step_c);
        if (sum_c > 17'(VEL_LIMIT)) begin
            acc_next_c = 16'(VEL_LIMIT);
        end else if (sum_c < -17'(VEL_LIMIT)) begin
            acc_next_c = -16'(VEL_LIMIT);
        end else begin
            acc_next_c = 16'(sum_c);
        end
        window_end_c = (win_cnt == WIN_LAST);
    end

    // Reference tracking: any legal new code becomes the reference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_idx   <= '0;
            ref_valid <= 1'b0;
        end else if (code_changed) begin
            if (illegal_c) begin
                ref_valid <= 1'b0;
            end else begin
                ref_idx   <= new_idx_c;
                ref_valid <= 1'b1;
            end
        end
    end

    // Window counter, accumulator and published outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt        <= '0;
            acc            <= '0;
            fault_flag     <= 1'b0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
            hall_fault     <= 1'b0;
        end else if (window_end_c) begin
            win_cnt        <= '0;
            acc            <= '0;
            fault_flag     <= 1'b0;
            velocity       <= acc_next_c;
            velocity_valid <= 1'b1;
            hall_fault     <= fault_flag | fault_c;
        end else begin
            win_cnt        <= win_cnt + WIN_W'(1);
            acc            <= acc_next_c;
            fault_flag     <= fault_flag | fault_c;
            velocity_valid <= 1'b0;
        end
    end

    // Direction follows counted steps only, independent of the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            direction <= 1'b0;
        end else if (step_c != 2'sd0) begin
            direction <= (step_c < 2'sd0);
        end
    end

endmodule

// File: tb/tb_bldc_hall_velocity_estimator.sv
// Bench for bldc_hall_velocity_estimator: directed and random hall sequences
// checked against a per-window step/fault reference model.
module tb_bldc_hall_velocity_estimator;

    localparam int WIN     = 100;
    localparam int LAT     = 6;      // drive-to-accumulate offset in window-counter terms
    localparam int NWIN    = 1024;
    localparam int SAT_WIN = 70000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  hall;
    logic [2:0]  hall2;
    logic signed [15:0] velocity, velocity2;
    logic        velocity_valid, velocity_valid2;
    logic        direction, direction2;
    logic        hall_fault, hall_fault2;

    int n_checks = 0;
    int n_errors = 0;
    int ecount;

    logic [2:0] hall_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    // Reference model state
    int   win_acc [NWIN];
    bit   win_flt [NWIN];
    logic [2:0] m_filt;
    bit   m_ref_valid;
    int   m_ref;
    bit   m_dir;
    int   cur_idx;

    bldc_hall_velocity_estimator #(
        .WINDOW_CYCLES (WIN), .FILTER_CYCLES (4), .SYNC_STAGES (2)
    ) dut (
        .clk (clk), .reset (reset), .hall (hall),
        .velocity (velocity), .velocity_valid (velocity_valid),
        .direction (direction), .hall_fault (hall_fault)
    );

    bldc_hall_velocity_estimator #(
        .WINDOW_CYCLES (SAT_WIN), .FILTER_CYCLES (1), .SYNC_STAGES (2)
    ) dut_sat (
        .clk (clk), .reset (reset), .hall (hall2),
        .velocity (velocity2), .velocity_valid (velocity_valid2),
        .direction (direction2), .hall_fault (hall_fault2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int seq_idx(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (hall_seq[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NWIN; i++) begin
            win_acc[i] = 0;
            win_flt[i] = 1'b0;
        end
        m_filt = 3'b000;
        m_ref_valid = 1'b0;
        m_ref = 0;
        m_dir = 1'b0;
    endtask

    // Accepted code change driven after edge d lands in window (d+LAT)/WIN.
    task automatic model_event(input logic [2:0] code, input int d);
        int w, idx, dl;
        if (code == m_filt) return;
        m_filt = code;
        w = (d + LAT) / WIN;
        idx = seq_idx(code);
        if (idx < 0) begin
            win_flt[w] = 1'b1;
            m_ref_valid = 1'b0;
        end else if (!m_ref_valid) begin
            m_ref = idx;
            m_ref_valid = 1'b1;
        end else begin
            dl = (idx - m_ref + 6) % 6;
            if (dl == 1) begin
                if (win_acc[w] < 32767) win_acc[w] = win_acc[w] + 1;
                m_dir = 1'b0;
            end else if (dl == 5) begin
                if (win_acc[w] > -32767) win_acc[w] = win_acc[w] - 1;
                m_dir = 1'b1;
            end else begin
                win_flt[w] = 1'b1;
            end
            m_ref = idx;
        end
    endtask

    task automatic tick();
        int w;
        @(negedge clk);
        chk("valid", 32'(velocity_valid), 32'(ecount != 0 && ecount % WIN == 0));
        if (velocity_valid) begin
            w = ecount / WIN - 1;
            if (w >= 0 && w < NWIN) begin
                chk("velocity", 32'(velocity), 32'(win_acc[w]));
                chk("hall_fault", 32'(hall_fault), 32'(win_flt[w]));
                chk("direction", 32'(direction), 32'(m_dir));
            end
        end
    endtask

    task automatic wait_mod(input int m, input int r);
        for (int i = 0; i < m && (ecount % m) != r; i++) tick();
    endtask

    task automatic drive_code(input logic [2:0] c);
        wait_mod(20, 10);
        hall = c;
        model_event(c, ecount);
        tick();
    endtask

    task automatic drive_idx(input int idx);
        cur_idx = (idx % 6 + 6) % 6;
        drive_code(hall_seq[cur_idx]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_velocity", 32'(velocity), 32'(0));
        chk("rst_valid", 32'(velocity_valid), 32'(0));
        chk("rst_direction", 32'(direction), 32'(0));
        chk("rst_fault", 32'(hall_fault), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        model_event(hall, 0);
    endtask

    initial begin
        int r;
        bit seen;
        logic [2:0] orig;
        reset = 1'b1;
        hall = 3'b001;
        hall2 = 3'b001;
        cur_idx = 0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Idle windows with hall held at 001
        repeat (3 * WIN) tick();

        // Forward then reverse at one code per 20 cycles
        for (int i = 0; i < 20; i++) drive_idx(cur_idx + 1);
        for (int i = 0; i < 20; i++) drive_idx(cur_idx - 1);

        // Reversal inside one window
        wait_mod(WIN, 1);
        for (int i = 0; i < 3; i++) drive_idx(cur_idx + 1);
        for (int i = 0; i < 2; i++) drive_idx(cur_idx - 1);
        repeat (2 * WIN) tick();

        // Skipped step, then a clean window
        drive_idx(cur_idx + 2);
        repeat (2 * WIN) tick();

        // Illegal code, then recovery
        drive_code(3'b111);
        drive_idx(cur_idx);
        repeat (2 * WIN) tick();

        // Random sequence
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: drive_idx(cur_idx + 1);
                4, 5, 6:    drive_idx(cur_idx - 1);
                7:          repeat (20) tick();
                8:          drive_idx(cur_idx + int'($urandom_range(2, 3)));
                default:    drive_code(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111);
            endcase
        end
        drive_idx(0);
        repeat (2 * WIN) tick();

        // Short glitch: filtered out
        wait_mod(WIN, 30);
        orig = hall;
        hall = hall_seq[(cur_idx + 1) % 6];
        tick(); tick();
        hall = orig;
        repeat (2 * WIN) tick();

        // Glitch one cycle longer than the filter: accepted as a step
        wait_mod(WIN, 30);
        hall = hall_seq[(cur_idx + 1) % 6];
        model_event(hall, ecount);
        repeat (5) tick();
        hall = orig;
        model_event(hall, ecount);
        repeat (2 * WIN) tick();

        // Reset mid-window with +3 accumulated
        wait_mod(WIN, 1);
        for (int i = 0; i < 3; i++) drive_idx(cur_idx + 1);
        wait_mod(WIN, 80);
        do_reset();
        for (int i = 0; i < 2; i++) drive_idx(cur_idx + 1);
        repeat (2 * WIN) tick();

        // Saturation: FILTER_CYCLES=1 instance, a step every two cycles
        hall2 = 3'b001;
        do_reset();
        chk("sat_rst_velocity", 32'(velocity2), 32'(0));
        r = 0;
        seen = 1'b0;
        for (int i = 0; i < SAT_WIN + 20 && !seen; i++) begin
            if (ecount % 2 == 0) begin
                r = (r + 1) % 6;
                hall2 = hall_seq[r];
            end
            tick();
            if (velocity_valid2) begin
                seen = 1'b1;
                chk("sat_strobe_time", 32'(ecount), 32'(SAT_WIN));
                chk("sat_velocity", 32'(velocity2), 32'(32767));
                chk("sat_fault", 32'(hall_fault2), 32'(0));
                chk("sat_direction", 32'(direction2), 32'(0));
            end
        end
        chk("sat_strobe_seen", 32'(seen), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
